// File: rtl/dma_dsc_issuer.sv
// Descriptor-bypass initiator: splits host transfer commands into length- and boundary-limited
// descriptors and drives them onto the bypass load handshake under an outstanding-credit limit.
module dma_dsc_issuer #(
  parameter int unsigned MAX_DSC_LEN     = 4096,
  parameter int unsigned BOUNDARY_LOG2   = 12,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             pcie_clk,
  input  logic             pcie_aresetn,
  input  logic             s_cmd_valid,
  output logic             s_cmd_ready,
  input  logic [63:0]      s_cmd_addr,
  input  logic [31:0]      s_cmd_len,
  input  logic             dsc_byp_ready,
  output logic [63:0]      dsc_byp_addr,
  output logic [31:0]      dsc_byp_len,
  output logic             dsc_byp_load,
  input  logic             dsc_done,
  output logic             busy,
  output logic [OUT_W-1:0] outstanding,
  output logic [31:0]      cmd_cnt,
  output logic [31:0]      dsc_cnt
);

  typedef enum logic [1:0] {StIdle, StCalc, StIssue} state_e;

  localparam logic [63:0]      BndMask = (64'd1 << BOUNDARY_LOG2) - 64'd1;
  localparam logic [32:0]      BndSize = 33'(64'd1 << BOUNDARY_LOG2);
  localparam logic [32:0]      MaxLen  = 33'(MAX_DSC_LEN);
  localparam logic [OUT_W-1:0] MaxOut  = OUT_W'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic [63:0]      cur_addr_q, cur_addr_d;
  logic [31:0]      rem_len_q, rem_len_d;
  logic [63:0]      dsc_addr_q, dsc_addr_d;
  logic [31:0]      dsc_len_q, dsc_len_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [31:0]      cmd_cnt_q, cmd_cnt_d;
  logic [31:0]      dsc_cnt_q, dsc_cnt_d;
  logic             load;

  // Chunk size, evaluated 33 bits wide so 2^BOUNDARY_LOG2 - offset cannot overflow.
  logic [32:0] to_bnd;
  logic [32:0] lim;
  logic [31:0] chunk;

  always_comb begin
    to_bnd = BndSize - 33'(cur_addr_q & BndMask);
    lim    = (MaxLen < to_bnd) ? MaxLen : to_bnd;
    chunk  = (lim < {1'b0, rem_len_q}) ? lim[31:0] : rem_len_q;
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    dsc_addr_d = dsc_addr_q;
    dsc_len_d  = dsc_len_q;
    cmd_cnt_d  = cmd_cnt_q;
    dsc_cnt_d  = dsc_cnt_q;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_cmd_valid && cmd_ready_q) begin
          cmd_cnt_d  = cmd_cnt_q + 32'd1;
          cur_addr_d = s_cmd_addr;
          rem_len_d  = s_cmd_len;
          if (s_cmd_len != 32'd0) state_d = StCalc;
        end
      end
      StCalc: begin
        dsc_addr_d = cur_addr_q;
        dsc_len_d  = chunk;
        state_d    = StIssue;
      end
      StIssue: begin
        if (dsc_byp_ready && (out_q < MaxOut)) begin
          load       = 1'b1;
          cur_addr_d = cur_addr_q + {32'd0, dsc_len_q};
          rem_len_d  = rem_len_q - dsc_len_q;
          dsc_cnt_d  = dsc_cnt_q + 32'd1;
          state_d    = (rem_len_d == 32'd0) ? StIdle : StCalc;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
  end

  // A completion with nothing outstanding (and no concurrent load) is dropped.
  always_comb begin
    out_d = out_q;
    unique case ({load, dsc_done})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   if (out_q != '0) out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      rem_len_q   <= '0;
      dsc_addr_q  <= '0;
      dsc_len_q   <= '0;
      cmd_ready_q <= 1'b0;
      out_q       <= '0;
      cmd_cnt_q   <= '0;
      dsc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_len_q   <= rem_len_d;
      dsc_addr_q  <= dsc_addr_d;
      dsc_len_q   <= dsc_len_d;
      cmd_ready_q <= cmd_ready_d;
      out_q       <= out_d;
      cmd_cnt_q   <= cmd_cnt_d;
      dsc_cnt_q   <= dsc_cnt_d;
    end
  end

  assign s_cmd_ready  = cmd_ready_q;
  assign dsc_byp_addr = dsc_addr_q;
  assign dsc_byp_len  = dsc_len_q;
  assign dsc_byp_load = load;
  assign busy         = (state_q != StIdle) || (out_q != '0);
  assign outstanding  = out_q;
  assign cmd_cnt      = cmd_cnt_q;
  assign dsc_cnt      = dsc_cnt_q;

endmodule

// File: tb/tb_dma_dsc_issuer.sv
// Directed self-checking bench for dma_dsc_issuer with hand-computed descriptor sequences.
module tb_dma_dsc_issuer;

  localparam int unsigned OUT_W = 5;

  logic             pcie_clk = 1'b0;
  logic             pcie_aresetn = 1'b0;
  logic             s_cmd_valid = 1'b0;
  logic             s_cmd_ready;
  logic [63:0]      s_cmd_addr = '0;
  logic [31:0]      s_cmd_len = '0;
  logic             dsc_byp_ready = 1'b0;
  logic [63:0]      dsc_byp_addr;
  logic [31:0]      dsc_byp_len;
  logic             dsc_byp_load;
  logic             dsc_done = 1'b0;
  logic             busy;
  logic [OUT_W-1:0] outstanding;
  logic [31:0]      cmd_cnt;
  logic [31:0]      dsc_cnt;

  always #5 pcie_clk = ~pcie_clk;

  dma_dsc_issuer #(
    .MAX_DSC_LEN    (4096),
    .BOUNDARY_LOG2  (12),
    .MAX_OUTSTANDING(16),
    .OUT_W          (OUT_W)
  ) dut (
    .pcie_clk     (pcie_clk),
    .pcie_aresetn (pcie_aresetn),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .s_cmd_addr   (s_cmd_addr),
    .s_cmd_len    (s_cmd_len),
    .dsc_byp_ready(dsc_byp_ready),
    .dsc_byp_addr (dsc_byp_addr),
    .dsc_byp_len  (dsc_byp_len),
    .dsc_byp_load (dsc_byp_load),
    .dsc_done     (dsc_done),
    .busy         (busy),
    .outstanding  (outstanding),
    .cmd_cnt      (cmd_cnt),
    .dsc_cnt      (dsc_cnt)
  );

  // Inputs change just after posedge, so load seen at negedge is what the next edge captures.
  logic [63:0] mon_addr[$];
  logic [31:0] mon_len[$];
  int unsigned bad_load = 0;

  always @(negedge pcie_clk) begin
    if (dsc_byp_load) begin
      mon_addr.push_back(dsc_byp_addr);
      mon_len.push_back(dsc_byp_len);
      if (!dsc_byp_ready) bad_load++;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [63:0] addr, input logic [31:0] len);
    int i = 0;
    while (!s_cmd_ready && i < 50) begin
      tick();
      i++;
    end
    if (!s_cmd_ready) check_eq("cmd_ready_timeout", 64'(s_cmd_ready), 64'd1);
    s_cmd_valid = 1'b1;
    s_cmd_addr  = addr;
    s_cmd_len   = len;
    tick();
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_loads(input int n, input int budget);
    int i = 0;
    while (mon_addr.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (mon_addr.size() < n) check_eq("load_timeout", 64'(mon_addr.size()), 64'(n));
  endtask

  task automatic drain();
    int i = 0;
    while (busy && i < 400) begin
      dsc_done = (outstanding != '0);
      tick();
      i++;
    end
    dsc_done = 1'b0;
    check_eq("drain_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_dsc(input string tag, input int idx, input logic [63:0] addr,
                           input logic [31:0] len);
    logic [63:0] ga;
    logic [31:0] gl;
    ga = (idx < mon_addr.size()) ? mon_addr[idx] : '1;
    gl = (idx < mon_len.size()) ? mon_len[idx] : '1;
    check_eq({tag, "_addr"}, ga, addr);
    check_eq({tag, "_len"}, 64'(gl), 64'(len));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_eq("rst_ready", 64'(s_cmd_ready), 64'd0);
    check_eq("rst_load", 64'(dsc_byp_load), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_outstanding", 64'(outstanding), 64'd0);
    check_eq("rst_cmd_cnt", 64'(cmd_cnt), 64'd0);
    check_eq("rst_dsc_cnt", 64'(dsc_cnt), 64'd0);
    check_eq("rst_addr", dsc_byp_addr, 64'd0);
    check_eq("rst_len", 64'(dsc_byp_len), 64'd0);
    pcie_aresetn = 1'b1;
    check_eq("ready_at_release", 64'(s_cmd_ready), 64'd0);
    tick();
    check_eq("ready_after_release", 64'(s_cmd_ready), 64'd1);

    // Aligned split with ready held high
    dsc_byp_ready = 1'b1;
    send_cmd(64'h1000, 32'h3000);
    check_eq("lat_calc_noload", 64'(dsc_byp_load), 64'd0);
    check_eq("ready_low_busy", 64'(s_cmd_ready), 64'd0);
    tick();
    check_eq("lat_first_load", 64'(dsc_byp_load), 64'd1);
    wait_loads(3, 50);
    repeat (3) tick();
    check_eq("aligned_count", 64'(mon_addr.size()), 64'd3);
    check_dsc("aligned0", 0, 64'h1000, 32'h1000);
    check_dsc("aligned1", 1, 64'h2000, 32'h1000);
    check_dsc("aligned2", 2, 64'h3000, 32'h1000);
    check_eq("aligned_dsc_cnt", 64'(dsc_cnt), 64'd3);
    check_eq("aligned_cmd_cnt", 64'(cmd_cnt), 64'd1);
    check_eq("aligned_outstanding", 64'(outstanding), 64'd3);
    drain();

    // Boundary splits, including an address that wraps past 2^64-1
    mon_addr.delete();
    mon_len.delete();
    send_cmd(64'h0FF0, 32'h40);
    wait_loads(2, 50);
    send_cmd(64'hFFFF_FFFF_FFFF_F000, 32'h1000);
    wait_loads(3, 50);
    send_cmd(64'h1800, 32'h2000);
    wait_loads(6, 50);
    repeat (3) tick();
    check_eq("bnd_count", 64'(mon_addr.size()), 64'd6);
    check_dsc("bnd0", 0, 64'h0FF0, 32'h10);
    check_dsc("bnd1", 1, 64'h1000, 32'h30);
    check_dsc("wrap0", 2, 64'hFFFF_FFFF_FFFF_F000, 32'h1000);
    check_dsc("mid0", 3, 64'h1800, 32'h800);
    check_dsc("mid1", 4, 64'h2000, 32'h1000);
    check_dsc("mid2", 5, 64'h3000, 32'h800);
    check_eq("bnd_dsc_cnt", 64'(dsc_cnt), 64'd9);
    check_eq("bnd_cmd_cnt", 64'(cmd_cnt), 64'd4);
    drain();

    // Backpressure: hold, then toggle ready
    mon_addr.delete();
    mon_len.delete();
    dsc_byp_ready = 1'b0;
    send_cmd(64'h1000, 32'h3000);
    tick();
    check_eq("bp_hold_load", 64'(dsc_byp_load), 64'd0);
    check_eq("bp_hold_addr", dsc_byp_addr, 64'h1000);
    check_eq("bp_hold_len", 64'(dsc_byp_len), 64'h1000);
    repeat (4) tick();
    check_eq("bp_stable_addr", dsc_byp_addr, 64'h1000);
    check_eq("bp_stable_len", 64'(dsc_byp_len), 64'h1000);
    check_eq("bp_no_loads", 64'(mon_addr.size()), 64'd0);
    begin
      logic [15:0] pat;
      pat = 16'b1010_0110_0011_1001;
      for (int i = 0; i < 80 && mon_addr.size() < 3; i++) begin
        dsc_byp_ready = pat[i % 16];
        tick();
      end
    end
    dsc_byp_ready = 1'b1;
    wait_loads(3, 20);
    repeat (3) tick();
    check_eq("bp_count", 64'(mon_addr.size()), 64'd3);
    check_dsc("bp0", 0, 64'h1000, 32'h1000);
    check_dsc("bp1", 1, 64'h2000, 32'h1000);
    check_dsc("bp2", 2, 64'h3000, 32'h1000);
    check_eq("bp_dsc_cnt", 64'(dsc_cnt), 64'd12);
    drain();

    // Credit limit
    mon_addr.delete();
    mon_len.delete();
    send_cmd(64'h0, 32'h20000);
    repeat (80) tick();
    check_eq("credit_stall_count", 64'(mon_addr.size()), 64'd16);
    check_eq("credit_outstanding", 64'(outstanding), 64'd16);
    check_eq("credit_load_low", 64'(dsc_byp_load), 64'd0);
    check_eq("credit_busy", 64'(busy), 64'd1);
    dsc_done = 1'b1;
    tick();
    dsc_done = 1'b0;
    check_eq("credit_after_done", 64'(outstanding), 64'd15);
    check_eq("credit_reload", 64'(dsc_byp_load), 64'd1);
    dsc_done = 1'b1;
    tick();
    dsc_done = 1'b0;
    check_eq("done_with_load", 64'(outstanding), 64'd15);
    check_eq("done_with_load_cnt", 64'(mon_addr.size()), 64'd17);
    repeat (10) tick();
    check_eq("credit_restall_count", 64'(mon_addr.size()), 64'd18);
    check_eq("credit_restall_out", 64'(outstanding), 64'd16);
    drain();
    check_eq("credit_total", 64'(mon_addr.size()), 64'd32);
    check_dsc("credit16", 16, 64'h10000, 32'h1000);
    check_dsc("credit31", 31, 64'h1F000, 32'h1000);
    check_eq("credit_dsc_cnt", 64'(dsc_cnt), 64'd44);
    check_eq("credit_cmd_cnt", 64'(cmd_cnt), 64'd6);

    // Stray completion at zero outstanding is ignored
    dsc_done = 1'b1;
    tick();
    dsc_done = 1'b0;
    check_eq("done_at_zero", 64'(outstanding), 64'd0);

    // Zero-length command
    mon_addr.delete();
    mon_len.delete();
    send_cmd(64'h5000, 32'h0);
    check_eq("len0_busy", 64'(busy), 64'd0);
    check_eq("len0_ready", 64'(s_cmd_ready), 64'd1);
    repeat (5) tick();
    check_eq("len0_cmd_cnt", 64'(cmd_cnt), 64'd7);
    check_eq("len0_no_load", 64'(mon_addr.size()), 64'd0);
    check_eq("len0_dsc_cnt", 64'(dsc_cnt), 64'd44);

    // Reset during the second of three descriptors
    send_cmd(64'h1000, 32'h3000);
    tick();
    tick();
    dsc_byp_ready = 1'b0;
    tick();
    check_eq("mid_second_addr", dsc_byp_addr, 64'h2000);
    pcie_aresetn = 1'b0;
    #1;
    check_eq("mid_rst_load", 64'(dsc_byp_load), 64'd0);
    check_eq("mid_rst_addr", dsc_byp_addr, 64'd0);
    check_eq("mid_rst_len", 64'(dsc_byp_len), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_out", 64'(outstanding), 64'd0);
    check_eq("mid_rst_cmd_cnt", 64'(cmd_cnt), 64'd0);
    check_eq("mid_rst_dsc_cnt", 64'(dsc_cnt), 64'd0);
    check_eq("mid_rst_ready", 64'(s_cmd_ready), 64'd0);
    dsc_byp_ready = 1'b1;
    repeat (3) tick();
    check_eq("mid_rst_no_more", 64'(mon_addr.size()), 64'd1);
    pcie_aresetn = 1'b1;
    tick();
    mon_addr.delete();
    mon_len.delete();
    send_cmd(64'h0FF0, 32'h40);
    wait_loads(2, 50);
    repeat (3) tick();
    check_dsc("post_rst0", 0, 64'h0FF0, 32'h10);
    check_dsc("post_rst1", 1, 64'h1000, 32'h30);
    check_eq("post_rst_cmd_cnt", 64'(cmd_cnt), 64'd1);
    check_eq("post_rst_dsc_cnt", 64'(dsc_cnt), 64'd2);
    drain();

    check_eq("load_without_ready", 64'(bad_load), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_dsc_issuer.md
Name: dma_dsc_issuer

Overview:
Descriptor-bypass initiator that sits in front of one direction (C2H or H2C) of the DMA driver's descriptor bypass port. It accepts host-buffer transfer commands (64-bit address, 32-bit byte length) on a valid/ready channel. Each command is split into descriptors that respect a maximum descriptor length and never cross a 2^BOUNDARY_LOG2-byte address boundary. Descriptors are driven onto the ready/load bypass handshake, with the number of uncompleted descriptors limited by a credit count.

Parameters:
MAX_DSC_LEN, 4096, maximum bytes per descriptor; legal range 1..2^28-1 (28-bit engine length field).
BOUNDARY_LOG2, 12, log2 of the address boundary a descriptor must not cross (4 KB).
MAX_OUTSTANDING, 16, maximum number of descriptors loaded but not yet completed.
OUT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
pcie_clk  in  1  single clock for all logic
pcie_aresetn  in  1  asynchronous active-low reset
s_cmd_valid  in  1  command valid
s_cmd_ready  out  1  command accepted when valid&ready
s_cmd_addr  in  64  host byte address
s_cmd_len  in  32  transfer length in bytes
dsc_byp_ready  in  1  engine can take a descriptor this cycle
dsc_byp_addr  out  64  descriptor host address
dsc_byp_len  out  32  descriptor byte length
dsc_byp_load  out  1  one-cycle descriptor load strobe
dsc_done  in  1  one-cycle pulse: one descriptor completed
busy  out  1  command in progress or outstanding != 0
outstanding  out  OUT_W  descriptors loaded and not yet completed
cmd_cnt  out  32  commands accepted (wraps)
dsc_cnt  out  32  descriptors loaded (wraps)

Behaviour:
- Reset, asynchronous on pcie_aresetn low: all registers cleared. s_cmd_ready=0, dsc_byp_load=0, dsc_byp_addr=0, dsc_byp_len=0, busy=0, outstanding=0, cmd_cnt=0, dsc_cnt=0. FSM enters IDLE. Reset mid-command discards the remaining split without emitting further loads.
- FSM states: IDLE, CALC, ISSUE.
- IDLE: s_cmd_ready=1 (registered; asserted the first cycle after reset release).
  - On valid&ready: latch cur_addr and rem_len, increment cmd_cnt.
  - If s_cmd_len==0: stay in IDLE and emit no descriptor; cmd_cnt still increments.
  - Otherwise go to CALC; s_cmd_ready=0 until the return to IDLE.
- CALC (one cycle): chunk = min(rem_len, MAX_DSC_LEN, 2^BOUNDARY_LOG2 - cur_addr[BOUNDARY_LOG2-1:0]). Register chunk into dsc_byp_len and cur_addr into dsc_byp_addr, then go to ISSUE. Compute the arithmetic 33 bits wide so no intermediate result overflows.
- ISSUE: dsc_byp_load=1 exactly in a cycle where dsc_byp_ready=1 and outstanding < MAX_OUTSTANDING (combinational gating by ready is allowed; load must never be high while ready is low).
  - On load: cur_addr += chunk, rem_len -= chunk, dsc_cnt++.
  - Then go to IDLE if rem_len after subtraction is 0, else CALC.
  - dsc_byp_addr and dsc_byp_len stay stable throughout ISSUE.
- Throughput: minimum 2 cycles per descriptor. IDLE→CALC→ISSUE gives 2 cycles from command accept to first load.
- Address arithmetic is 64-bit modular: a wrap past 2^64-1 simply wraps. The boundary rule guarantees a descriptor never spans the wrap.
- outstanding:
  - +1 on load; -1 on dsc_done; unchanged when both occur in the same cycle.
  - dsc_done while outstanding==0 (with no load) is ignored; the counter saturates at 0.
  - Stays ≤ MAX_OUTSTANDING; when at the limit, ISSUE holds with load low.
- busy = (state != IDLE) | (outstanding != 0).
- cmd_cnt and dsc_cnt wrap modulo 2^32.

Test Plan:
- Reset and idle: release reset → s_cmd_ready=1 one cycle later; all counters and outputs 0; dsc_byp_load never high.
- Aligned split: addr 0x1000, len 0x3000, ready held 1 → exactly three loads (0x1000/0x1000, 0x2000/0x1000, 0x3000/0x1000); dsc_cnt=3; cmd_cnt=1.
- Boundary split: addr 0x0FF0, len 0x40 → loads 0x0FF0/0x10 then 0x1000/0x30. Addr 0xFFFF_FFFF_FFFF_F000, len 0x1000 → single load, cur_addr wraps to 0.
- Backpressure: random dsc_byp_ready toggling → load only when ready=1; addr/len stable while waiting; sequence matches the ready-held-1 case.
- Credit limit: len 0x20000 with no dsc_done → 16 loads then stall with outstanding=16. One dsc_done pulse → exactly one more load. A dsc_done coinciding with a load leaves outstanding unchanged.
- Edge cases: len 0 → accepted, cmd_cnt+1, no load, busy stays 0. Reset asserted during the 2nd of 3 descriptors → no further loads, all outputs 0 immediately; a new command afterwards is processed normally.
